logical_unit_pipe: RTL and testbench

- Pipelined, parametrised successor to the combinational logical unit; WIDTH-bit operands, registered results, valid/ready flow control.
- Adds shift/rotate ops, a defined result and error flag for invalid fn_sel, and a zero flag.
- Sits between the operand/decode stage and the result bus of the datapath. Sustains one op per cycle; latency 2 cycles when not stalled.

---
 rtl/logical_unit_pipe.sv | 106 ++++++++++
 tb/tb_logical_unit_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logical_unit_pipe.sv
// Two-stage pipelined logical/shift unit with valid/ready flow control.
// S1 captures operands, S2 holds the computed result that drives the outputs.
module logical_unit_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       fn_sel,
  input  logic             op_en,
  output logic             in_ready,
  output logic             out_en,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             op_err,
  output logic             zero
);

  // Returns {err, result}; undefined opcodes yield a zero result with err set.
  function automatic logic [WIDTH:0] logic_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [3:0]       fn);
    logic [WIDTH-1:0]   r;
    logic               err;
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] rot;
    sh  = b[SHW-1:0];
    rot = {a, a} << sh;
    r   = '0;
    err = 1'b0;
    case (fn)
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = ~a;
      4'b1001: r = ~(a & b);
      4'b1010: r = ~(a | b);
      4'b1011: r = a ^ b;
      4'b1100: r = ~(a ^ b);
      4'b1101: r = a << sh;
      4'b1110: r = a >> sh;
      4'b1111: r = rot[2*WIDTH-1:WIDTH];
      default: begin
        r   = '0;
        err = 1'b1;
      end
    endcase
    return {err, r};
  endfunction

  logic [WIDTH-1:0] a_p1, b_p1;
  logic [3:0]       fn_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] res_p2;
  logic             err_p2, zero_p2, vld_p2;
  logic             adv_p1, adv_p2;
  logic [WIDTH:0]   op_res_p1;

  always_comb begin
    adv_p2    = ~vld_p2 | out_ready;
    adv_p1    = ~vld_p1 | adv_p2;
    op_res_p1 = logic_op(a_p1, b_p1, fn_p1);
  end

  assign in_ready = adv_p1;
  assign out_en   = vld_p2;
  assign data_out = res_p2;
  assign op_err   = err_p2;
  assign zero     = zero_p2;

  // Stage 1: operand capture
  always_ff @(posedge clk) begin
    if (adv_p1 && op_en) begin
      a_p1  <= A;
      b_p1  <= B;
      fn_p1 <= fn_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (adv_p1) begin
      vld_p1 <= op_en;
    end
  end

  // Stage 2: result register; loads only real ops so bubbles never disturb outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      res_p2  <= '0;
      err_p2  <= 1'b0;
      zero_p2 <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        res_p2  <= op_res_p1[WIDTH-1:0];
        err_p2  <= op_res_p1[WIDTH];
        zero_p2 <= (op_res_p1[WIDTH-1:0] == '0);
      end
    end
  end

endmodule

// File: tb/tb_logical_unit_pipe.sv
// Bench for logical_unit_pipe: directed vector table, handshake corner cases,
// and a randomized run scored against an arithmetic reference model.
module tb_logical_unit_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] A, B;
  logic [3:0] fn_sel;
  logic       op_en;
  logic       in_ready;
  logic       out_en;
  logic       out_ready;
  logic [7:0] data_out;
  logic       op_err;
  logic       zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logical_unit_pipe #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .fn_sel   (fn_sel),
    .op_en    (op_en),
    .in_ready (in_ready),
    .out_en   (out_en),
    .out_ready(out_ready),
    .data_out (data_out),
    .op_err   (op_err),
    .zero     (zero)
  );

  typedef struct {
    logic [3:0] fn;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       e;
    logic       z;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       e;
    logic       z;
    int         st;
  } exp_t;

  localparam int NV = 14;
  vec_t vt[NV];
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference behaviour from the opcode table, shifts done with powers of two.
  function automatic exp_t model(input logic [3:0] fn, input logic [7:0] a, input logic [7:0] b);
    exp_t o;
    int ai, bi, s, r;
    ai = int'(a);
    bi = int'(b);
    s  = bi % 8;
    r  = 0;
    o.e = 1'b0;
    case (int'(fn))
      6:  r = ai & bi;
      7:  r = ai | bi;
      8:  r = 255 - ai;
      9:  r = 255 - (ai & bi);
      10: r = 255 - (ai | bi);
      11: r = ai ^ bi;
      12: r = 255 - (ai ^ bi);
      13: r = (ai * (2 ** s)) % 256;
      14: r = ai / (2 ** s);
      15: r = (ai * (2 ** s)) % 256 + ai / (2 ** (8 - s));
      default: begin
        r   = 0;
        o.e = 1'b1;
      end
    endcase
    o.d  = r[7:0];
    o.z  = (r == 0);
    o.st = 0;
    return o;
  endfunction

  task automatic drive(input logic en, input logic [3:0] fn, input logic [7:0] a, input logic [7:0] b);
    op_en  = en;
    fn_sel = fn;
    A      = a;
    B      = b;
  endtask

  int         cyc;
  logic       pend;
  logic       held_v;
  logic [7:0] held_d;
  logic       held_e, held_z;
  exp_t       ex;

  initial begin
    vt[0]  = '{4'b0110, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vt[1]  = '{4'b1000, 8'h0F, 8'h5A, 8'hF0, 1'b0, 1'b0};
    vt[2]  = '{4'b1100, 8'hAA, 8'hAA, 8'hFF, 1'b0, 1'b0};
    vt[3]  = '{4'b1010, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[4]  = '{4'b1101, 8'h81, 8'h0B, 8'h08, 1'b0, 1'b0};
    vt[5]  = '{4'b1110, 8'h81, 8'h0B, 8'h10, 1'b0, 1'b0};
    vt[6]  = '{4'b1111, 8'h81, 8'h0B, 8'h0C, 1'b0, 1'b0};
    vt[7]  = '{4'b1111, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0};
    vt[8]  = '{4'b0011, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1};
    vt[9]  = '{4'b0111, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0};
    vt[10] = '{4'b1001, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};
    vt[11] = '{4'b1011, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0};
    vt[12] = '{4'b0000, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1};
    vt[13] = '{4'b0101, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};

    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_en", out_en, 0);
    chk("rst_data", data_out, 0);
    chk("rst_err", op_err, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 1);

    // Back-to-back vector stream, one op per cycle, result two edges after accept
    for (int k = 0; k < NV + 2; k++) begin
      if (k >= 2) begin
        chk($sformatf("vec%0d_out_en", k - 2), out_en, 1);
        chk($sformatf("vec%0d_data", k - 2), data_out, vt[k-2].d);
        chk($sformatf("vec%0d_err", k - 2), op_err, vt[k-2].e);
        chk($sformatf("vec%0d_zero", k - 2), zero, vt[k-2].z);
      end else begin
        chk($sformatf("vec_lat%0d_out_en", k), out_en, 0);
      end
      if (k < NV) begin
        chk($sformatf("vec%0d_in_ready", k), in_ready, 1);
        drive(1'b1, vt[k].fn, vt[k].a, vt[k].b);
      end else begin
        drive(1'b0, 4'h0, 8'h00, 8'h00);
      end
      @(negedge clk);
      #1;
    end

    // Backpressure: fill both stages, stall, then release
    out_ready = 1'b0;
    drive(1'b1, 4'b0111, 8'h11, 8'h00);
    #1 chk("bp0_in_ready", in_ready, 1);
    @(negedge clk);
    drive(1'b1, 4'b0111, 8'h22, 8'h00);
    #1 chk("bp1_in_ready", in_ready, 1);
    chk("bp1_out_en", out_en, 0);
    @(negedge clk);
    drive(1'b1, 4'b0111, 8'h33, 8'h00);
    #1 chk("bp_full_in_ready", in_ready, 0);
    chk("bp_full_out_en", out_en, 1);
    chk("bp_full_data", data_out, 8'h11);
    @(negedge clk);
    #1 chk("bp_hold_in_ready", in_ready, 0);
    chk("bp_hold_data", data_out, 8'h11);
    out_ready = 1'b1;
    #1 chk("bp_rel_in_ready", in_ready, 1);
    chk("bp_rel_data", data_out, 8'h11);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    #1 chk("bp_out2_en", out_en, 1);
    chk("bp_out2_data", data_out, 8'h22);
    @(negedge clk);
    #1 chk("bp_out3_en", out_en, 1);
    chk("bp_out3_data", data_out, 8'h33);
    @(negedge clk);
    #1 chk("bp_empty_out_en", out_en, 0);

    // Reset while both stages hold ops and the output is stalled
    out_ready = 1'b0;
    drive(1'b1, 4'b0110, 8'hFF, 8'h55);
    @(negedge clk);
    drive(1'b1, 4'b0111, 8'hA0, 8'h05);
    @(negedge clk);
    #1 chk("mr_full_in_ready", in_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    #1 chk("mr_out_en", out_en, 0);
    chk("mr_data", data_out, 0);
    chk("mr_err", op_err, 0);
    chk("mr_zero", zero, 0);
    chk("mr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("mr_no_stale%0d", k), out_en, 0);
    end

    // Randomized traffic with a scoreboard; the tail drains the pipe
    @(negedge clk);
    cyc    = 0;
    pend   = 1'b0;
    held_v = 1'b0;
    for (int i = 0; i < 2040; i++) begin
      if (i >= 2000) begin
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        out_ready = 1'b1;
      end else begin
        if (!pend)
          drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        out_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      chk("rnd_in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("rnd_out_en", out_en, (q.size() > 0) && (q[0].st < cyc));
      if (held_v) begin
        chk("rnd_hold_data", data_out, held_d);
        chk("rnd_hold_err", op_err, held_e);
        chk("rnd_hold_zero", zero, held_z);
      end
      if (out_en && out_ready && q.size() > 0) begin
        ex = q.pop_front();
        chk("rnd_data", data_out, ex.d);
        chk("rnd_err", op_err, ex.e);
        chk("rnd_zero", zero, ex.z);
      end
      held_v = out_en && !out_ready;
      held_d = data_out;
      held_e = op_err;
      held_z = zero;
      if (op_en && in_ready) begin
        ex    = model(fn_sel, A, B);
        ex.st = cyc + 1;
        q.push_back(ex);
      end
      pend = op_en && !in_ready;
      @(negedge clk);
      cyc++;
    end
    chk("rnd_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
